// File: rtl/dest_fifo_pkg.sv
// dest_fifo_pkg
// Shared sizing constants for the per-destination output path. The same
// word width and pointer width are used by demux_dest, dest_fifo and the
// flow-control FSM, so they live here rather than in any one module.
//   DATA_WIDTH : width of one buffered word (matches the demux output)
//   ADDR_WIDTH : FIFO pointer width; depth is 2**ADDR_WIDTH
//   DEPTH      : number of words held by one dest_fifo
package dest_fifo_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int ADDR_WIDTH = 2;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

endpackage

// File: rtl/dest_fifo_mem.sv
// dest_fifo_mem
// Register-array storage for dest_fifo: one synchronous write port and one
// synchronous, registered read port. The array itself is not reset; only
// the read register is, so data_out comes up as zero.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high, clears the read register only
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data holds its value when low
//   rd_addr  : read address
//   rd_data  : registered read data
module dest_fifo_mem
  import dest_fifo_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A read and a write to the same slot in one cycle (full FIFO with push
  // and pop together) returns the old word, which is the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dest_fifo.sv
// dest_fifo
// Per-destination output buffer placed on each demux output. Holds up to
// 2**ADDR_WIDTH words until the consumer pops them and reports occupancy,
// programmable almost-full/almost-empty flags and sticky error flags to
// the flow-control FSM.
// Ports:
//   clk           : rising-edge clock
//   reset         : asynchronous active-high, clears all state
//   data_in       : word from the demux
//   valid_in      : push request
//   pop           : read request from the consumer
//   umbral_af     : almost-full threshold (count >= umbral_af)
//   umbral_ae     : almost-empty threshold (count <= umbral_ae)
//   data_out      : registered read data, held when no pop is accepted
//   valid_out     : high for the cycle after an accepted pop
//   count         : occupancy, 0..2**ADDR_WIDTH
//   full, empty   : occupancy at depth / zero
//   almost_full   : occupancy at or above umbral_af
//   almost_empty  : occupancy at or below umbral_ae
//   err_overflow  : sticky, a push was dropped
//   err_underflow : sticky, a pop arrived while empty
module dest_fifo
  import dest_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = dest_fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = dest_fifo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_af,
  input  logic [ADDR_WIDTH:0]   umbral_ae,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  pop_acc;
  logic                  push_acc;

  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= umbral_af);
  assign almost_empty = (count <= umbral_ae);

  // A push into a full FIFO is still accepted when a pop frees a slot in
  // the same cycle. A pop on empty is never accepted, even with a push,
  // because there is no write-to-read bypass.
  assign pop_acc  = pop && !empty;
  assign push_acc = valid_in && (!full || pop_acc);

  dest_fifo_mem #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (pop_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  // Pointers wrap naturally at 2**ADDR_WIDTH; count carries the extra bit
  // that distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_acc;
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Error flags are sticky until reset so the flow-control FSM cannot miss
  // a single-cycle event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (valid_in && !push_acc) begin
        err_overflow <= 1'b1;
      end
      if (pop && empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule
